// File: rtl/k_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : k_alu_pkg
// Description : Shared definitions for the K_ALU datapath: operation codes,
//               sequencer state encoding and small op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package k_alu_pkg;

    // Operation encodings presented on the op port
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDK = 2'b10;
    localparam logic [1:0] OP_SUBK = 2'b11;

    // Sequencer states for the chunked add/subtract units
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True for the two subtracting operations
    function automatic logic op_is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SUBK);
    endfunction

    // True when operand B is replaced by the immediate constant
    function automatic logic op_uses_k(input logic [1:0] op);
        return (op == OP_ADDK) || (op == OP_SUBK);
    endfunction

endpackage : k_alu_pkg
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// ============================================================================
// Module      : addsub_chunk
// Description : Combinational CHUNK-bit add/subtract slice built as a ripple
//               of full_adder_1_bit cells. Operand B is inverted when sub=1,
//               the caller supplies the +1 through cin on the first chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_chunk
    import k_alu_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             sub,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_c,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0]   w_carry;
    logic [CHUNK-1:0] w_b_x;

    // Conditional inversion of B turns the adder into a subtractor
    assign w_b_x      = b_c ^ {CHUNK{sub}};
    assign w_carry[0] = cin;

    // Ripple chain, LSB cell first
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            full_adder_1_bit u_fa (
                .a    (a_c[gi]),
                .b    (w_b_x[gi]),
                .cin  (w_carry[gi]),
                .sum  (sum_c[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the slice and carry into its top cell (for overflow)
    assign cout     = w_carry[CHUNK];
    assign c_msb_in = w_carry[CHUNK-1];

endmodule : addsub_chunk
`default_nettype wire

// File: rtl/full_adder_1_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_1_bit
// Description : Single-bit full adder cell, the building block of the
//               chunk ripple.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_1_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Gate-level sum and carry of one bit position
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1_bit
`default_nettype wire

// File: rtl/seq_addsub_k.sv
`default_nettype none
// ============================================================================
// Module      : seq_addsub_k
// Description : Multi-cycle add/subtract unit (A+B, A-B, A+K, A-K). Operands
//               are processed CHUNK bits per clock through addsub_chunk, the
//               inter-chunk carry lives in a register. start/busy/done
//               handshake, carry/overflow/zero flags valid with done.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_addsub_k
    import k_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int K     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int                 c_N     = WIDTH / CHUNK;
    localparam int                 c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(c_N - 1);
    localparam logic [WIDTH-1:0]   c_K     = WIDTH'(K);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_sub;
    logic               r_cin;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [CHUNK-1:0]   w_a_c;
    logic [CHUNK-1:0]   w_b_c;
    logic [CHUNK-1:0]   w_sum_c;
    logic               w_cout;
    logic               w_c_msb_in;
    logic [WIDTH-1:0]   w_result_nxt;

    // A request is taken whenever the unit is not mid-computation
    assign w_run    = (r_state == ST_RUN);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = w_run && (r_idx == c_LAST);

    // Current chunk of each latched operand
    assign w_a_c = r_opa[r_idx*CHUNK +: CHUNK];
    assign w_b_c = r_opb[r_idx*CHUNK +: CHUNK];

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_c      (w_a_c),
        .b_c      (w_b_c),
        .sub      (r_sub),
        .cin      (r_cin),
        .sum_c    (w_sum_c),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Result with the current chunk merged in; also feeds the zero flag
    always_comb begin
        w_result_nxt = r_result;
        w_result_nxt[r_idx*CHUNK +: CHUNK] = w_sum_c;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: N RUN cycles, one DONE cycle, back-to-back from DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == c_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, chunk sequencing, result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_sub    <= 1'b0;
            r_cin    <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_opa    <= a;
            r_opb    <= op_uses_k(op) ? c_K : b;
            r_sub    <= op_is_sub(op);
            r_cin    <= op_is_sub(op);
            r_idx    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_run) begin
            r_result <= w_result_nxt;
            r_cin    <= w_cout;
            if (w_last) begin
                r_idx   <= '0;
                r_carry <= w_cout;
                r_ovf   <= w_c_msb_in ^ w_cout;
                r_zero  <= (w_result_nxt == '0);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Handshake outputs decode the registered state
    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule : seq_addsub_k
`default_nettype wire

// File: tb/tb_seq_addsub_k.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_addsub_k
// Description : Scoreboard bench for seq_addsub_k. The driver pushes the
//               arithmetic expectation of every accepted request, a monitor
//               pops and compares on each done pulse, including latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_addsub_k;

    parameter int CHUNK = 2;
    localparam int W     = 8;
    localparam int KC    = 4;
    localparam int c_N   = W / CHUNK;
    localparam longint c_MOD  = longint'(1) << W;
    localparam longint c_HALF = longint'(1) << (W - 1);

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry, overflow, zero;
    logic [W-1:0] result;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    seq_addsub_k #(.WIDTH(W), .CHUNK(CHUNK), .K(KC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^W, signed range test
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   e;
        longint ua, ub, sa, sb, full, tr;
        ua = longint'(av);
        ub = o[1] ? (longint'(KC) % c_MOD) : longint'(bv);
        sa = (ua >= c_HALF) ? ua - c_MOD : ua;
        sb = (ub >= c_HALF) ? ub - c_MOD : ub;
        if (o[0]) begin
            full = ua - ub;
            e.c  = (ua >= ub);
            tr   = sa - sb;
        end else begin
            full = ua + ub;
            e.c  = (full >= c_MOD);
            tr   = sa + sb;
        end
        full  = ((full % c_MOD) + c_MOD) % c_MOD;
        e.res = W'(full);
        e.v   = (tr > c_HALF - 1) || (tr < -c_HALF);
        e.z   = (e.res == '0);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            chk("done_one_cycle", prev_done, 1'b0);
            chk("busy_in_done", busy, 1'b0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result",   result,   e.res);
                chk("carry",    carry,    e.c);
                chk("overflow", overflow, e.v);
                chk("zero",     zero,     e.z);
                chk("latency",  cyc + 1 - e.acc, c_N + 1);
            end
        end
        prev_done = done;
    end

    // Issue one request as soon as the unit is free; return the accept edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, output int acc);
        exp_t e;
        int   guard = 0;
        while (busy === 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                $display("FAIL busy_timeout: got busy=1 for %0d cycles expected release", guard);
                errors++;
                $display("Result: errors=%0d of %0d checks", errors, checks + 1);
                $fatal(1, "stuck busy");
            end
        end
        start = 1'b1; op = o; a = av; b = bv;
        e = model(o, av, bv);
        e.acc = cyc + 1;
        acc = e.acc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    // Raise start with junk operands while the unit is busy
    task automatic spam(input int n);
        for (int i = 0; i < n; i++) begin
            if (busy === 1'b1) begin
                start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int acc1, acc2, dc;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", {carry, overflow, zero}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        // 05 - 03
        issue(2'b01, 8'h05, 8'h03, acc1);
        drain();
        chk("sub_res", result, 8'h02);
        chk("sub_flags", {carry, overflow, zero}, 3'b100);

        // 04 - K, then back-to-back 02 - K
        issue(2'b11, 8'h04, 8'hAA, acc1);
        issue(2'b11, 8'h02, 8'h33, acc2);
        chk("b2b_gap", acc2 - acc1, c_N + 1);
        drain();
        chk("subk_res", result, 8'hFE);
        chk("subk_flags", {carry, overflow, zero}, 3'b000);

        // Signed overflow, add and subtract
        issue(2'b00, 8'h7F, 8'h01, acc1);
        drain();
        chk("addovf_res", result, 8'h80);
        chk("addovf_flags", {carry, overflow}, 2'b01);
        issue(2'b01, 8'h80, 8'h01, acc1);
        drain();
        chk("subovf_res", result, 8'h7F);
        chk("subovf_flags", {carry, overflow}, 2'b11);

        // FE + K with start pulses while busy
        dc = done_cnt;
        issue(2'b10, 8'hFE, 8'h55, acc1);
        spam(3);
        drain();
        repeat (4) @(negedge clk);
        chk("addk_res", result, 8'h02);
        chk("addk_carry", carry, 1'b1);
        chk("single_done", done_cnt - dc, 1);

        // Asynchronous reset in the middle of RUN
        dc = done_cnt;
        issue(2'b00, 8'h12, 8'h34, acc1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_result", result, 8'h00);
        chk("midrst_flags", {carry, overflow, zero}, 3'b000);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (c_N + 4) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc, 0);
        issue(2'b01, 8'h05, 8'h03, acc1);
        drain();
        chk("post_rst_res", result, 8'h02);

        // Randomised traffic
        for (int i = 0; i < 1000; i++) begin
            issue(2'($urandom), W'($urandom), W'($urandom), acc1);
            if ($urandom_range(0, 3) == 0) spam($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_addsub_k
`default_nettype wire
